// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle main controller.
//   statetype  - 4-bit FSM state encoding (FETCH..JEX)
//   OP_*       - opcode field values (instr[31:26]) recognised by the controller
//   ALUOP_*    - aluop values consumed by the ALU decoder
//   SRCB_*     - alusrcb mux selects
//   PCSRC_*    - pcsrc mux selects
//   ctrl_t     - raw control word decoded from the current state
//   op_legal() - true for opcodes that DECODE knows how to dispatch
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } statetype;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic       branch;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_controller_if.sv
// mc_controller_if: controller <-> datapath/memory signal bundle.
//   master modport: the controller (samples opcode/zero/mem_ready, drives controls)
//   slave modport:  the datapath side (drives opcode/zero/mem_ready, samples controls)
interface mc_controller_if;

    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       illegal_op;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, aluop, pcsrc, pcen, illegal_op
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, aluop, pcsrc, pcen, illegal_op
    );

endinterface

// File: rtl/mc_outdec.sv
// mc_outdec: combinational state -> raw control word decoder.
//   state - current FSM state
//   ctrl  - ungated control word (mem_ready/reset gating is applied by the top)
// Unreachable encodings decode to an all-zero control word.
module mc_outdec
    import mc_pkg::*;
(
    input  statetype state,
    output ctrl_t    ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_req = 1'b1;
                ctrl.irwrite = 1'b1;
                ctrl.pcwrite = 1'b1;
                ctrl.alusrcb = SRCB_FOUR;
                ctrl.aluop   = ALUOP_ADD;
                ctrl.pcsrc   = PCSRC_ALU;
            end
            DECODE: begin
                ctrl.alusrcb = SRCB_IMMSH;
                ctrl.aluop   = ALUOP_ADD;
            end
            MEMADR, ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            MEMWB: begin
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            MEMWR: begin
                ctrl.mem_req  = 1'b1;
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            RTYPEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_B;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            RTYPEWB: begin
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            BEQEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_B;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.pcsrc   = PCSRC_ALUOUT;
                ctrl.branch  = 1'b1;
            end
            ADDIWB: begin
                ctrl.regwrite = 1'b1;
            end
            JEX: begin
                ctrl.pcsrc   = PCSRC_JUMP;
                ctrl.pcwrite = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle main control FSM for the MIPS-subset datapath.
//   clk   - system clock, rising edge
//   reset - asynchronous active-high; forces FETCH and blocks all write enables
//   bus   - mc_controller_if.master: opcode/zero/mem_ready in, datapath controls out
// USE_MEM_READY = 0 treats mem_ready as constant 1 (single-cycle memory states).
module mc_controller
    import mc_pkg::*;
#(
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    mc_controller_if.master   bus
);

    statetype state;
    ctrl_t    ctrl;
    logic     ready;
    logic     run;
    logic     mem_gate;

    assign ready = USE_MEM_READY ? bus.mem_ready : 1'b1;
    assign run   = ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:   if (ready) state <= DECODE;
                DECODE: begin
                    case (bus.opcode)
                        OP_LW, OP_SW: state <= MEMADR;
                        OP_RTYPE:     state <= RTYPEEX;
                        OP_BEQ:       state <= BEQEX;
                        OP_ADDI:      state <= ADDIEX;
                        OP_J:         state <= JEX;
                        default:      state <= FETCH;
                    endcase
                end
                MEMADR:  state <= (bus.opcode == OP_SW) ? MEMWR : MEMRD;
                MEMRD:   if (ready) state <= MEMWB;
                MEMWR:   if (ready) state <= FETCH;
                RTYPEEX: state <= RTYPEWB;
                ADDIEX:  state <= ADDIWB;
                // Writeback/branch/jump states and unreachable encodings all return to FETCH
                default: state <= FETCH;
            endcase
        end
    end

    mc_outdec u_outdec (
        .state (state),
        .ctrl  (ctrl)
    );

    // irwrite and the pcwrite term wait for the fetch access to complete
    assign mem_gate = (state != FETCH) || ready;

    // Enables are masked by reset combinationally so nothing strobes while the
    // asynchronous reset is taking effect
    assign bus.mem_req    = run & ctrl.mem_req;
    assign bus.memwrite   = run & ctrl.memwrite;
    assign bus.irwrite    = run & ctrl.irwrite & mem_gate;
    assign bus.regwrite   = run & ctrl.regwrite;
    assign bus.pcen       = run & ((ctrl.pcwrite & mem_gate) | (ctrl.branch & bus.zero));
    assign bus.illegal_op = run & (state == DECODE) & ~op_legal(bus.opcode);

    assign bus.iord     = ctrl.iord;
    assign bus.regdst   = ctrl.regdst;
    assign bus.memtoreg = ctrl.memtoreg;
    assign bus.alusrca  = ctrl.alusrca;
    assign bus.alusrcb  = ctrl.alusrcb;
    assign bus.aluop    = ctrl.aluop;
    assign bus.pcsrc    = ctrl.pcsrc;

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle main control FSM for the 32-bit MIPS-subset datapath. Sits directly upstream of the ALU decoder.
- Decodes the 6-bit opcode held in the instruction register and sequences fetch, decode, execute, memory and writeback.
- Produces datapath enables and muxes plus the 2-bit aluop consumed by the ALU decoder; aluop 00 = add, 01 = sub, 10 = use funct.
- Holds off on a memory-ready handshake so a slow memory can stretch FETCH and the memory states.

Parameters:
- USE_MEM_READY, 1, when 0 mem_ready is ignored and treated as constant 1; every memory state then completes in one cycle.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; forces state to FETCH
- opcode  input  6  instr[31:26] from the instruction register
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory has completed the current access this cycle
- mem_req  output  1  memory access requested (FETCH, MEMRD, MEMWR)
- iord  output  1  0 = address from PC, 1 = address from ALUOut
- memwrite  output  1  memory write strobe
- irwrite  output  1  instruction register load
- regdst  output  1  1 = rd, 0 = rt
- memtoreg  output  1  1 = write back memory data
- regwrite  output  1  register file write enable
- alusrca  output  1  0 = PC, 1 = register A
- alusrcb  output  2  00 B, 01 constant 4, 10 sign-extended immediate, 11 immediate<<2
- aluop  output  2  to ALU decoder
- pcsrc  output  2  00 ALU result, 01 ALUOut, 10 jump target
- pcen  output  1  PC load enable = pcwrite | (branch & zero)
- illegal_op  output  1  one-cycle pulse on an undecodable opcode

Behaviour:
- Reset: clk and reset only; reset is asynchronous, active-high.
  - State goes to FETCH immediately.
  - While reset is high, memwrite, irwrite, regwrite, pcen, mem_req and illegal_op are forced to 0.
  - All other outputs take their FETCH values.
  - A reset in the middle of an instruction abandons it. No write enable glitches high on assertion.
- Outputs are Moore (a function of the state) except where noted. Unlisted outputs are 0.
- States, outputs and transitions:
  - FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00. irwrite and the pcwrite term are both gated by mem_ready. Go to DECODE when mem_ready, else stay.
  - DECODE: alusrca=0, alusrcb=11, aluop=00 (branch target to ALUOut). Next state by opcode:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 (R-type) -> RTYPEEX
    - 000100 (beq) -> BEQEX
    - 001000 (addi) -> ADDIEX
    - 000010 (j) -> JEX
    - any other opcode -> FETCH, with illegal_op=1 for this cycle only (Mealy).
  - MEMADR: alusrca=1, alusrcb=10, aluop=00. Go to MEMRD for lw, MEMWR for sw.
  - MEMRD: mem_req=1, iord=1. Go to MEMWB when mem_ready, else stay.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1. Go to FETCH.
  - MEMWR: mem_req=1, iord=1, memwrite=1 (held every wait cycle). Go to FETCH when mem_ready, else stay.
  - RTYPEEX: alusrca=1, alusrcb=00, aluop=10. Go to RTYPEWB.
  - RTYPEWB: regdst=1, memtoreg=0, regwrite=1. Go to FETCH.
  - BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1. Go to FETCH.
  - ADDIEX: alusrca=1, alusrcb=10, aluop=00. Go to ADDIWB.
  - ADDIWB: regdst=0, memtoreg=0, regwrite=1. Go to FETCH.
  - JEX: pcsrc=10, pcwrite=1. Go to FETCH.
- pcen is combinational from the state and zero. In BEQEX, pcen follows the same-cycle zero.
- Cycle counts with mem_ready held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each cycle mem_ready is low adds one cycle in FETCH, MEMRD or MEMWR.
- The state register uses a 4-bit encoding. Any unreachable encoding returns to FETCH on the next clock with all enables 0.

Decomposition:
- Shared package mc_pkg holds:
  - statetype enum (FETCH..JEX, 4-bit)
  - opcode constants OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J
  - aluop constants ALUOP_ADD=2'b00, ALUOP_SUB=2'b01, ALUOP_FUNCT=2'b10
  - alusrcb and pcsrc encodings
- One sub-module: mc_outdec, a combinational state-to-control-word decoder. The top holds the state register, next-state logic, the mem_ready gating and the pcen logic.

Test Plan:
- Reset held high, mem_ready=1 -> irwrite=0, pcen=0, mem_req=0, memwrite=0, regwrite=0. Release reset -> next cycle irwrite=1, pcen=1, alusrcb=01, aluop=00.
- opcode=100011, mem_ready=1 -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB. regwrite=1 with memtoreg=1 in cycle 5 only; back in FETCH in cycle 6.
- opcode=000000 -> RTYPEEX shows aluop=10, alusrca=1, alusrcb=00. RTYPEWB shows regdst=1, regwrite=1. Total 4 cycles.
- opcode=000100: with zero=1 -> pcen=1, pcsrc=01 in BEQEX. With zero=0 -> pcen=0. Both return to FETCH after 3 cycles.
- opcode=101011, mem_ready low for 3 cycles in MEMWR -> memwrite=1 for 4 consecutive cycles, then FETCH. Repeat with mem_ready low 2 cycles in FETCH -> irwrite and pcen stay 0 until mem_ready rises.
- opcode=111111 -> illegal_op=1 for the DECODE cycle only, then FETCH with no regwrite or memwrite. Assert reset mid-MEMWR -> memwrite drops immediately and state is FETCH.
